// File: rtl/obi_mem_arbiter.sv
// Two-port OBI arbiter: core fetch and load/store share one memory port, with an in-order tag FIFO routing responses.
// Define OBI_ARB_DATA_PRIORITY_EN for fixed data-port priority; otherwise ties are broken round-robin.
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    err_o
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTST);
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTST - 1);

    logic [CW-1:0]        cnt_q;
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [MAX_OUTST-1:0] tag_q;   // 1 = data port owns the entry
    logic                 err_q;
    logic                 sel_data, accept, pop;

    // Full is judged on the registered count, so a same-cycle pop cannot free a slot.
    assign mem_req_o = (instr_req_i | data_req_i) && (cnt_q < FULL) && !rst_i;

`ifdef OBI_ARB_DATA_PRIORITY_EN
    assign sel_data = data_req_i;
`else
    logic rr_q;
    assign sel_data = data_req_i && (!instr_req_i || rr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rr_q <= 1'b0;
        else if (accept && instr_req_i && data_req_i)
            rr_q <= ~sel_data;
    end
`endif

    assign accept      = mem_req_o && mem_gnt_i;
    assign instr_gnt_o = accept && !sel_data;
    assign data_gnt_o  = accept && sel_data;

    assign mem_we_o    = sel_data && data_we_i;
    assign mem_be_o    = sel_data ? data_be_i    : '1;
    assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = sel_data ? data_wdata_i : '0;

    assign pop            = mem_rvalid_i && (cnt_q != '0) && !rst_i;
    assign instr_rvalid_o = pop && !tag_q[rptr_q];
    assign data_rvalid_o  = pop && tag_q[rptr_q];
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                tag_q[wptr_q] <= sel_data;
                wptr_q        <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
            end
            if (pop)
                rptr_q <= (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // A response with nothing outstanding is dropped and flagged until reset.
            if (mem_rvalid_i && (cnt_q == '0))
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios plus random traffic, checked by a queue-based reference model.
module tb_obi_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
`ifdef OBI_ARB_DATA_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            instr_req_i = 1'b0, data_req_i = 1'b0;
    logic [AW-1:0]   instr_addr_i = '0, data_addr_i = '0;
    logic            data_we_i = 1'b0;
    logic [DW/8-1:0] data_be_i = '0;
    logic [DW-1:0]   data_wdata_i = '0;
    logic            mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [DW-1:0]   mem_rdata_i = '0;
    logic            instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [DW-1:0]   instr_rdata_o, data_rdata_o, mem_wdata_o;
    logic            mem_req_o, mem_we_o, err_o;
    logic [DW/8-1:0] mem_be_o;
    logic [AW-1:0]   mem_addr_o;

    obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owners of accepted-but-unanswered transfers in issue order,
    // plus which port is preferred on the next tie (the one that lost the last tie).
    bit exp_q[$];
    bit pref_data = 1'b0;
    bit err_m = 1'b0;
    bit i_acc = 1'b0, d_acc = 1'b0;
    bit m_req, m_win, m_owner;

    // Monitor/scoreboard: samples mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        i_acc = 1'b0;
        d_acc = 1'b0;
        if (rst_i) begin
            chk("reset_outputs", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}, 5'b0);
            exp_q.delete();
            pref_data = 1'b0;
            err_m = 1'b0;
        end else begin
            chk("err", err_o, err_m);
            m_req = (instr_req_i || data_req_i) && (exp_q.size() < MO);
            chk("mem_req", mem_req_o, m_req);
            if (instr_req_i && data_req_i) m_win = PRIO ? 1'b1 : pref_data;
            else                           m_win = data_req_i;
            if (m_req) begin
                chk("mem_addr", mem_addr_o, m_win ? data_addr_i : instr_addr_i);
                chk("mem_we", mem_we_o, m_win ? data_we_i : 1'b0);
                chk("mem_be", mem_be_o, m_win ? data_be_i : 4'hF);
                chk("mem_wdata", mem_wdata_o, m_win ? data_wdata_i : 32'h0);
            end
            chk("gnt", {instr_gnt_o, data_gnt_o},
                {m_req && mem_gnt_i && !m_win, m_req && mem_gnt_i && m_win});
            // Responses are resolved before this cycle's push: a same-cycle
            // response with an empty queue is spurious.
            if (mem_rvalid_i && exp_q.size() > 0) begin
                m_owner = exp_q.pop_front();
                chk("rvalid", {instr_rvalid_o, data_rvalid_o}, {!m_owner, m_owner});
                chk("rdata", m_owner ? data_rdata_o : instr_rdata_o, mem_rdata_i);
            end else begin
                if (mem_rvalid_i) err_m = 1'b1;
                chk("rvalid_idle", {instr_rvalid_o, data_rvalid_o}, 2'b00);
            end
            if (m_req && mem_gnt_i) begin
                exp_q.push_back(m_win);
                if (instr_req_i && data_req_i) pref_data = !m_win;
                i_acc = !m_win;
                d_acc = m_win;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        repeat (2) step();
        rst_i = 1'b0;
    endtask

    bit ipend, dpend;

    initial begin
        do_reset();
        @(negedge clk);
        chk("reset_err", err_o, 1'b0);

        // Single fetch.
        step();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("fetch_gnt", instr_gnt_o, 1'b1);
        chk("fetch_addr", mem_addr_o, 32'h100);
        step();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("fetch_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b10);
        chk("fetch_rdata", instr_rdata_o, 32'hDEADBEEF);

        // Contention: both request for four cycles, response one cycle behind each grant.
        for (int c = 0; c < 4; c++) begin
            step();
            instr_req_i = 1'b1; instr_addr_i = 32'h200 + c;
            data_req_i = 1'b1; data_addr_i = 32'h300 + c; data_we_i = c[0]; data_be_i = 4'h3;
            data_wdata_i = 32'hA000 + c; mem_gnt_i = 1'b1;
            mem_rvalid_i = (c > 0); mem_rdata_i = 32'h5500 + c;
            @(negedge clk);
            chk("contention_order", {instr_gnt_o, data_gnt_o},
                PRIO ? 2'b01 : (c[0] ? 2'b01 : 2'b10));
        end
        step();
        idle(); mem_rvalid_i = 1'b1;
        step();
        idle();

        // Full: two grants without responses, then a response in the blocked cycle.
        for (int c = 0; c < 3; c++) begin
            step();
            instr_req_i = 1'b1; instr_addr_i = 32'h400 + c; mem_gnt_i = 1'b1;
            mem_rvalid_i = (c == 2);
            @(negedge clk);
            if (c == 2) chk("full_block", mem_req_o, 1'b0);
        end
        step();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("full_resume", instr_gnt_o, 1'b1);
        step();
        idle(); mem_rvalid_i = 1'b1;
        step();
        step();
        idle();

        // Random traffic, requesters holding their request until granted.
        ipend = 1'b0; dpend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (i_acc) ipend = 1'b0;
            if (d_acc) dpend = 1'b0;
            if (!ipend && $urandom_range(0, 2) == 0) begin
                ipend = 1'b1; instr_addr_i = $urandom;
            end
            if (!dpend && $urandom_range(0, 2) == 0) begin
                dpend = 1'b1; data_addr_i = $urandom; data_we_i = $urandom_range(0, 1);
                data_be_i = 4'($urandom_range(0, 15)); data_wdata_i = $urandom;
            end
            instr_req_i  = ipend;
            data_req_i   = dpend;
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
        end
        step();
        idle();
        for (int n = 0; n < 8 && exp_q.size() > 0; n++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
            step();
        end
        idle();
        chk("drained", exp_q.size(), 0);

        // Spurious response after reset.
        do_reset();
        step();
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        chk("spurious_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        step();
        idle();
        @(negedge clk);
        chk("spurious_err", err_o, 1'b1);

        // Reset with two transactions outstanding.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            step();
            data_req_i = 1'b1; data_addr_i = 32'h800 + c; mem_gnt_i = 1'b1;
        end
        step();
        idle();
        do_reset();
        step();
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        chk("post_reset_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        step();
        idle();
        @(negedge clk);
        chk("post_reset_err", err_o, 1'b1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/obi_mem_arbiter.md
OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports; byte enables are DATA_WIDTH/8 bits.
REQ-003 SHALL have parameter MAX_OUTST, default 2, maximum accepted-but-unanswered transactions (range 1..8).
REQ-004 SHALL have a single clock and an asynchronous active-high reset, as follows.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all registers on the rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have instr_req_i/instr_gnt_o/instr_rvalid_o, in/out/out, 1 each, core fetch handshake.
REQ-008 SHALL have instr_addr_i (in, ADDR_WIDTH) and instr_rdata_o (out, DATA_WIDTH), fetch address and fetch data.
REQ-009 SHALL have data_req_i/data_gnt_o/data_rvalid_o, in/out/out, 1 each, core load/store handshake.
REQ-010 SHALL have data_we_i (in, 1), data_be_i (in, DATA_WIDTH/8), data_addr_i (in, ADDR_WIDTH), data_wdata_i (in, DATA_WIDTH) and data_rdata_o (out, DATA_WIDTH).
REQ-011 SHALL have mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o as outputs, plus mem_gnt_i, mem_rvalid_i and mem_rdata_i as inputs, forming the shared memory port.
REQ-012 SHALL have err_o, out, 1, sticky protocol-error flag.

Function
REQ-013 SHALL drive mem_req_o combinationally when (instr_req_i or data_req_i) and outstanding count < MAX_OUTST.
REQ-014 SHALL select the winner combinationally: a single requester wins; when both request, the port indicated by the round-robin pointer rr_q wins (0 = instr, 1 = data).
REQ-015 SHALL drive the mem_* request fields from the winner; when the fetch port wins, mem_we_o=0, mem_be_o=all ones and mem_wdata_o=0.
REQ-016 SHALL assert the winner's gnt output only in the cycle of mem_req_o && mem_gnt_i; the loser's gnt output is 0.
REQ-017 SHALL, on each accepted transfer, set rr_q to the port that lost; rr_q is unchanged when only one port requested.
REQ-018 SHALL push the 1-bit owner ID into an in-order tag FIFO of depth MAX_OUTST on each accepted transfer.
REQ-019 SHALL, on mem_rvalid_i with a non-empty FIFO, pulse the head owner's rvalid output in the same cycle with rdata = mem_rdata_i, and pop the FIFO; the other rvalid output is 0.
REQ-020 SHALL block new requests when the FIFO is full, even if mem_rvalid_i pops in the same cycle; grant resumes the following cycle.
REQ-021 SHALL allow a push and a pop in the same cycle when the FIFO is not full; the count is then unchanged.
REQ-022 SHALL ignore mem_rvalid_i with an empty FIFO and set err_o=1, which stays set until reset.
REQ-023 SHALL require each requester to hold req and its fields stable until gnt; the arbiter does not check this.
REQ-024 SHALL make the FIFO read and write pointers wrap modulo MAX_OUTST.
REQ-025 SHALL drive both rdata outputs with mem_rdata_i at all times; only the rvalid outputs qualify them.

Reset
REQ-026 SHALL, while rst_i=1, clear the FIFO (count=0, pointers=0) and set rr_q=0 and err_o=0.
REQ-027 SHALL hold all gnt and rvalid outputs and mem_req_o at 0 while rst_i=1.
REQ-028 SHALL discard responses that were outstanding when reset was asserted mid-operation.

Configuration
REQ-029 SHALL, when macro OBI_ARB_DATA_PRIORITY_EN is defined, give the data port fixed priority whenever both ports request; rr_q is then not implemented.
REQ-030 SHALL, without OBI_ARB_DATA_PRIORITY_EN, use the round-robin arbitration of REQ-014 and REQ-017.

Verification
REQ-031 SHALL cover a single fetch: instr_req_i=1 at addr 0x100 with mem_gnt_i=1 -> instr_gnt_o=1 in the same cycle; mem_rvalid_i with 0xDEADBEEF the next cycle -> instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF.
REQ-032 SHALL cover contention: both ports request for 4 cycles with mem_gnt_i=1 and rvalid following each grant one cycle later -> grant order instr, data, instr, data.
REQ-033 SHALL cover full: MAX_OUTST=2, two grants with no rvalid -> mem_req_o=0 on the third cycle; rvalid in that cycle -> gnt the following cycle.
REQ-034 SHALL cover a spurious response: mem_rvalid_i=1 after reset with no request -> err_o=1, both rvalid outputs 0.
REQ-035 SHALL cover reset mid-operation: reset asserted with 2 transactions outstanding, then released -> FIFO empty; the next mem_rvalid_i sets err_o.
REQ-036 SHALL cover priority mode: with OBI_ARB_DATA_PRIORITY_EN defined and both ports requesting for 3 cycles -> data_gnt_o=1 on all 3 cycles and instr_gnt_o=0.
